// File: rtl/weight_bank_pkg.sv
// Shared types and constants for the ping-pong convolution weight bank.
// The offset helper defines the position-major / channel-minor read-data layout.
package weight_bank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } load_state_t;

    localparam int DEF_BANKS  = 8;
    localparam int DEF_KPOS   = 9;
    localparam int DEF_WW     = 8;
    localparam int DEF_DEPTH  = 1024;
    localparam int DEF_RD_LAT = 3;

    // Bit offset of weight (position p, channel bank b) in the MAC-facing bus.
    function automatic int pos_major_offset(input int p, input int b, input int banks, input int ww);
        return (p * banks + b) * ww;
    endfunction

endpackage

// File: rtl/wb_uram_bank.sv
// One output-channel bank: both halves in a single array, addressed {half, addr},
// with an RD_LAT-deep read pipe whose stages advance only behind valid data.
module wb_uram_bank #(
    parameter int KPOS   = 9,
    parameter int WW     = 8,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 3,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [ADDR_W:0]        wr_addr,
    input  logic [KPOS*WW-1:0]     wr_data,
    input  logic [ADDR_W:0]        rd_addr,
    input  logic [RD_LAT-1:0]      stage_en,
    output logic [KPOS*WW-1:0]     rd_data
);

    localparam int WORD_W = KPOS * WW;

    logic [WORD_W-1:0] mem [2*DEPTH];
    logic [RD_LAT-1:0][WORD_W-1:0] pipe_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Stages hold when no valid word passes, so the output keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_reg <= '0;
        end else begin
            if (stage_en[0]) begin
                pipe_reg[0] <= mem[rd_addr];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                if (stage_en[i]) begin
                    pipe_reg[i] <= pipe_reg[i-1];
                end
            end
        end
    end

    assign rd_data = pipe_reg[RD_LAT-1];

endmodule

// File: rtl/weight_bank_pp.sv
// Double-buffered weight store: a streaming loader fills the shadow half while
// the conv engine reads the active half; a swap handshake exchanges them.
module weight_bank_pp
    import weight_bank_pkg::*;
#(
    parameter int BANKS  = DEF_BANKS,
    parameter int KPOS   = DEF_KPOS,
    parameter int WW     = DEF_WW,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load_start,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [KPOS*WW-1:0]                wr_data,
    input  logic                              wr_last,
    output logic                              shadow_ready,
    output logic [ADDR_W+$clog2(BANKS):0]     load_count,
    output logic                              load_err,
    input  logic                              swap_req,
    output logic                              swap_ack,
    output logic                              active_buf,
    input  logic                              rd_en,
    input  logic [ADDR_W-1:0]                 rd_addr,
    output logic                              rd_valid,
    output logic [BANKS*KPOS*WW-1:0]          rd_data
);

    localparam int WORD_W = KPOS * WW;
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int CNT_W  = ADDR_W + $clog2(BANKS) + 1;

    load_state_t        state_reg, state_next;
    logic [BANK_W-1:0]  bank_cnt_reg, bank_cnt_next;
    logic [ADDR_W-1:0]  addr_cnt_reg, addr_cnt_next;
    logic [CNT_W-1:0]   load_count_reg, load_count_next;
    logic               load_err_reg, load_err_next;
    logic               active_buf_reg, active_buf_next;
    logic               swap_ack_reg, swap_ack_next;
    logic [RD_LAT-1:0]  vld_reg;

    logic               beat_acc;
    logic               last_slot;
    logic [ADDR_W:0]    rd_phys;
    logic [ADDR_W:0]    wr_phys;
    logic [RD_LAT-1:0]  stage_en;
    logic [BANKS-1:0][WORD_W-1:0] bank_rd;

    // A beat coinciding with load_start is dropped by the restart.
    assign beat_acc  = (state_reg == LOAD) && wr_valid && !load_start;
    assign last_slot = (bank_cnt_reg == BANK_W'(BANKS-1)) && (addr_cnt_reg == ADDR_W'(DEPTH-1));

    always_comb begin
        state_next      = state_reg;
        bank_cnt_next   = bank_cnt_reg;
        addr_cnt_next   = addr_cnt_reg;
        load_count_next = load_count_reg;
        load_err_next   = load_err_reg;
        active_buf_next = active_buf_reg;
        swap_ack_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load_start) begin
                    state_next      = LOAD;
                    bank_cnt_next   = '0;
                    addr_cnt_next   = '0;
                    load_count_next = '0;
                    load_err_next   = 1'b0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    bank_cnt_next   = '0;
                    addr_cnt_next   = '0;
                    load_count_next = '0;
                    load_err_next   = 1'b0;
                end else if (wr_valid) begin
                    if (bank_cnt_reg == BANK_W'(BANKS-1)) begin
                        bank_cnt_next = '0;
                        addr_cnt_next = addr_cnt_reg + ADDR_W'(1);
                    end else begin
                        bank_cnt_next = bank_cnt_reg + BANK_W'(1);
                    end
                    load_count_next = load_count_reg + CNT_W'(1);
                    if (wr_last) begin
                        state_next = FULL;
                    end else if (last_slot) begin
                        state_next    = FULL;
                        load_err_next = 1'b1;
                    end
                end
            end
            FULL: begin
                if (swap_req) begin
                    state_next      = IDLE;
                    active_buf_next = ~active_buf_reg;
                    swap_ack_next   = 1'b1;
                end else if (load_start) begin
                    state_next      = LOAD;
                    bank_cnt_next   = '0;
                    addr_cnt_next   = '0;
                    load_count_next = '0;
                    load_err_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            bank_cnt_reg   <= '0;
            addr_cnt_reg   <= '0;
            load_count_reg <= '0;
            load_err_reg   <= 1'b0;
            active_buf_reg <= 1'b0;
            swap_ack_reg   <= 1'b0;
            vld_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            bank_cnt_reg   <= bank_cnt_next;
            addr_cnt_reg   <= addr_cnt_next;
            load_count_reg <= load_count_next;
            load_err_reg   <= load_err_next;
            active_buf_reg <= active_buf_next;
            swap_ack_reg   <= swap_ack_next;
            vld_reg[0]     <= rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_reg[i] <= vld_reg[i-1];
            end
        end
    end

    assign wr_ready     = (state_reg == LOAD);
    assign shadow_ready = (state_reg == FULL);
    assign load_count   = load_count_reg;
    assign load_err     = load_err_reg;
    assign swap_ack     = swap_ack_reg;
    assign active_buf   = active_buf_reg;
    assign rd_valid     = vld_reg[RD_LAT-1];

    // The half bit is captured with the address, so in-flight reads survive a swap.
    assign rd_phys = {active_buf_reg, rd_addr};
    assign wr_phys = {~active_buf_reg, addr_cnt_reg};

    assign stage_en[0] = rd_en;
    genvar gi, gp;
    generate
        for (gi = 1; gi < RD_LAT; gi++) begin : g_stage_en
            assign stage_en[gi] = vld_reg[gi-1];
        end

        for (gi = 0; gi < BANKS; gi++) begin : g_bank
            wb_uram_bank #(
                .KPOS   (KPOS),
                .WW     (WW),
                .DEPTH  (DEPTH),
                .RD_LAT (RD_LAT),
                .ADDR_W (ADDR_W)
            ) u_bank (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr_en    (beat_acc && (bank_cnt_reg == BANK_W'(gi))),
                .wr_addr  (wr_phys),
                .wr_data  (wr_data),
                .rd_addr  (rd_phys),
                .stage_en (stage_en),
                .rd_data  (bank_rd[gi])
            );

            for (gp = 0; gp < KPOS; gp++) begin : g_pos
                assign rd_data[pos_major_offset(gp, gi, BANKS, WW) +: WW] = bank_rd[gi][gp*WW +: WW];
            end
        end
    endgenerate

endmodule

// File: tb/tb_weight_bank_pp.sv
// Directed bench for weight_bank_pp: load, swap, read pipeline, overflow and reset.
module tb_weight_bank_pp;

    localparam int BANKS  = 8;
    localparam int KPOS   = 9;
    localparam int WW     = 8;
    localparam int DEPTH  = 16;
    localparam int RD_LAT = 3;
    localparam int ADDR_W = 4;
    localparam int OUT_W  = BANKS*KPOS*WW;

    logic               clk;
    logic               rst_n;
    logic               load_start;
    logic               wr_valid;
    logic               wr_ready;
    logic [KPOS*WW-1:0] wr_data;
    logic               wr_last;
    logic               shadow_ready;
    logic [7:0]         load_count;
    logic               load_err;
    logic               swap_req;
    logic               swap_ack;
    logic               active_buf;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_valid;
    logic [OUT_W-1:0]   rd_data;

    int n_cmp = 0;
    int n_err = 0;

    weight_bank_pp #(
        .BANKS(BANKS), .KPOS(KPOS), .WW(WW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
        .shadow_ready(shadow_ready), .load_count(load_count), .load_err(load_err),
        .swap_req(swap_req), .swap_ack(swap_ack), .active_buf(active_buf),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected MAC-ordered word: pattern 0 = beat index a*8+b, pattern 1 = 0xA0+b.
    function automatic logic [OUT_W-1:0] exp_pat(input int a, input bit alt);
        logic [OUT_W-1:0] r;
        logic [7:0] v;
        r = '0;
        for (int p = 0; p < KPOS; p++) begin
            for (int b = 0; b < BANKS; b++) begin
                v = alt ? 8'(8'hA0 + b) : 8'(a*BANKS + b);
                r[(p*BANKS + b)*WW +: WW] = v;
            end
        end
        return r;
    endfunction

    task automatic do_load(input int nbeats, input bit with_last);
        logic [7:0] v;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int n = 0; n < nbeats; n++) begin
            v        = 8'(n);
            wr_valid = 1'b1;
            wr_data  = {KPOS{v}};
            wr_last  = with_last && (n == nbeats-1);
            tick();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    logic [OUT_W-1:0] last_exp;
    logic             en_seq   [22];
    logic [3:0]       addr_seq [22];
    logic [7:0]       vb;

    initial begin
        rst_n = 1'b0; load_start = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        swap_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
        tick(); tick();
        check("rst_wr_ready", wr_ready, 0);
        check("rst_shadow_ready", shadow_ready, 0);
        check("rst_load_count", load_count, 0);
        check("rst_load_err", load_err, 0);
        check("rst_swap_ack", swap_ack, 0);
        check("rst_active_buf", active_buf, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();

        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("idle_swap_ack", swap_ack, 0);
        check("idle_active_buf", active_buf, 0);

        do_load(128, 1'b1);
        check("load1_shadow_ready", shadow_ready, 1);
        check("load1_count", load_count, 128);
        check("load1_err", load_err, 0);
        check("load1_wr_ready", wr_ready, 0);

        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("swap1_ack", swap_ack, 1);
        check("swap1_active_buf", active_buf, 1);
        tick();
        check("swap1_ack_pulse", swap_ack, 0);
        check("swap1_idle_shadow", shadow_ready, 0);

        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        rd_en = 1'b0;
        check("rd5_lat1_valid", rd_valid, 0);
        tick();
        check("rd5_lat2_valid", rd_valid, 0);
        tick();
        check("rd5_lat3_valid", rd_valid, 1);
        check("rd5_data", rd_data, exp_pat(5, 1'b0));
        last_exp = exp_pat(5, 1'b0);

        for (int c = 0; c < 22; c++) begin
            en_seq[c]   = (c < 16) || (c == 17);
            addr_seq[c] = (c < 16) ? 4'(c) : 4'd3;
        end
        for (int c = 0; c < 22; c++) begin
            rd_en   = en_seq[c];
            rd_addr = addr_seq[c];
            tick();
            if (c >= 2 && en_seq[c-2]) last_exp = exp_pat(int'(addr_seq[c-2]), 1'b0);
            check($sformatf("burst_valid_c%0d", c), rd_valid, (c >= 2) ? en_seq[c-2] : 1'b0);
            check($sformatf("burst_data_c%0d", c), rd_data, last_exp);
        end
        rd_en = 1'b0;

        load_start = 1'b1; rd_en = 1'b1; rd_addr = 4'd2;
        tick();
        load_start = 1'b0;
        for (int n = 0; n < 128; n++) begin
            vb       = 8'(8'hA0 + (n % BANKS));
            wr_valid = 1'b1;
            wr_data  = {KPOS{vb}};
            wr_last  = (n == 127);
            tick();
            if (n >= 1) begin
                check($sformatf("shadow_rd_valid_n%0d", n), rd_valid, 1);
                check($sformatf("shadow_rd_data_n%0d", n), rd_data, exp_pat(2, 1'b0));
            end
        end
        wr_valid = 1'b0; wr_last = 1'b0;
        check("load2_shadow_ready", shadow_ready, 1);
        check("load2_active_buf", active_buf, 1);

        swap_req = 1'b1; rd_en = 1'b1; rd_addr = 4'd0;
        tick();
        swap_req = 1'b0;
        check("swap2_ack", swap_ack, 1);
        check("swap2_active_buf", active_buf, 0);
        tick();
        rd_en = 1'b0;
        tick();
        check("swapcycle_rd_valid", rd_valid, 1);
        check("swapcycle_rd_old", rd_data, exp_pat(0, 1'b0));
        tick();
        check("postswap_rd_valid", rd_valid, 1);
        check("postswap_rd_new", rd_data, exp_pat(0, 1'b1));
        tick();
        check("postswap_idle_valid", rd_valid, 0);
        check("postswap_hold_data", rd_data, exp_pat(0, 1'b1));

        do_load(128, 1'b0);
        check("ovf_shadow_ready", shadow_ready, 1);
        check("ovf_load_err", load_err, 1);
        check("ovf_load_count", load_count, 128);
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("ovf_extra_wr_ready", wr_ready, 0);
        check("ovf_extra_count", load_count, 128);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("restart_load_err", load_err, 0);
        check("restart_wr_ready", wr_ready, 1);
        check("restart_count", load_count, 0);

        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("load_swap_ack", swap_ack, 0);
        check("load_active_buf", active_buf, 0);

        wr_valid = 1'b1; wr_data = '0;
        tick(); tick(); tick();
        check("partial_count", load_count, 3);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("drop_beat_count", load_count, 0);
        for (int n = 0; n < 8; n++) begin
            wr_last = (n == 7);
            tick();
        end
        wr_valid = 1'b0; wr_last = 1'b0;
        check("short_load_full", shadow_ready, 1);
        check("short_load_count", load_count, 8);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("swap3_active_buf", active_buf, 1);

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        wr_valid = 1'b1;
        tick(); tick();
        rd_en = 1'b1; rd_addr = 4'd0;
        tick(); tick();
        rd_en = 1'b0;
        check("prereset_wr_ready", wr_ready, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_wr_ready", wr_ready, 0);
        check("midrst_rd_valid", rd_valid, 0);
        check("midrst_shadow_ready", shadow_ready, 0);
        check("midrst_active_buf", active_buf, 0);
        check("midrst_load_count", load_count, 0);
        wr_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("postrst_rd_valid_c%0d", c), rd_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
